warp_sched: RTL
===============

WARP_SCHED -- requirements
Module: warp_sched

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warp contexts (2..16).
REQ-002 SHALL have parameter THREADS_PER_WARP, default 4, threads per warp (power of two, 1..16).
REQ-003 SHALL have parameter PC_BITS, default 8, program counter width.
REQ-004 SHALL have ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- start  in  1  kernel launch pulse.
- thread_count  in  8  total threads in block.
- issue_valid  out  1  warp offered to pipeline.
- issue_ready  in  1  pipeline accepts offered warp.
- issue_warp_id  out  $clog2(NUM_WARPS)  offered warp index.
- issue_pc  out  PC_BITS  offered warp PC.
- issue_thread_mask  out  THREADS_PER_WARP  active lanes of offered warp.
- retire_valid  in  1  pipeline finished one instruction of a warp.
- retire_warp_id  in  $clog2(NUM_WARPS)  retiring warp.
- retire_next_pc  in  PC_BITS  PC for next instruction.
- retire_done  in  1  warp executed RET.
- done  out  1  all active warps finished.
- err  out  1  sticky protocol/config error.
- perf_issue_count  out  16  accepted issues (see Configuration).
- perf_stall_cycles  out  16  cycles in RUN with issue_valid=0.

Function
REQ-005 SHALL implement top FSM IDLE -> RUN -> DONE; start ignored outside IDLE.
REQ-006 On start in IDLE: active warps W = ceil(thread_count/THREADS_PER_WARP), clamped to NUM_WARPS; warps 0..W-1 become READY with pc=0; others INACTIVE; next state RUN.
REQ-007 Warp W-1 mask SHALL have low (thread_count mod THREADS_PER_WARP) bits set when remainder nonzero; all other active warps full mask.
REQ-008 thread_count > NUM_WARPS*THREADS_PER_WARP SHALL set err and launch clamped.
REQ-009 thread_count=0 SHALL go IDLE -> RUN -> DONE with no issue.
REQ-010 Per-warp states SHALL be INACTIVE, READY, PENDING (in issue slot), ISSUED (accepted), FINISHED.
REQ-011 Issue slot registered: at an edge in RUN where slot empty or being accepted, SHALL load next READY warp in round-robin order starting after last loaded warp id; warp goes READY -> PENDING; issue_valid=1 next cycle.
REQ-012 issue_* SHALL hold stable while issue_valid=1 and issue_ready=0.
REQ-013 issue_valid & issue_ready at edge: warp PENDING -> ISSUED; back-to-back issue of different warps every cycle SHALL be supported.
REQ-014 retire_valid for ISSUED warp: retire_done=0 -> READY, pc=retire_next_pc; retire_done=1 -> FINISHED.
REQ-015 Retired warp SHALL be eligible for selection no earlier than the edge after retire.
REQ-016 retire_valid for warp not ISSUED SHALL be ignored and set err.
REQ-017 Simultaneous retire of warp A and accept of warp B SHALL both take effect.
REQ-018 When all active warps FINISHED, FSM SHALL enter DONE next edge; done=1 held until reset.
REQ-019 A single warp SHALL never be PENDING or ISSUED twice concurrently (one instruction in flight per warp).

Reset
REQ-020 reset=0 at edge SHALL force IDLE, all warps INACTIVE, pc=0, round-robin pointer to NUM_WARPS-1, issue_valid=0, done=0, err=0, perf counters 0, issue_* data 0.
REQ-021 reset mid-RUN SHALL discard slot and all warp state with no further issue.

Configuration
REQ-022 Macro WARP_SCHED_PERF_EN defined: perf_issue_count increments per accepted issue, perf_stall_cycles per RUN cycle with issue_valid=0; both saturate at 16'hFFFF, clear on start.
REQ-023 Macro undefined: perf ports present, tied to 0, no counter logic.

Verification
REQ-024 NUM_WARPS=4,TPW=4, thread_count=10, issue_ready=1, retire each warp 2 cycles after accept with done=0 -> W=3, ids 0,1,2,0..., warp 2 mask 4'b0011.
REQ-025 thread_count=0, start -> done=1 on third cycle after start, issue_valid never 1.
REQ-026 thread_count=40 (cap 16) -> err=1, four warps launched, all masks 4'b1111.
REQ-027 issue_ready=0 for 5 cycles with warp 1 offered, warp 2 retired meanwhile -> issue_warp_id stays 1, pc unchanged.
REQ-028 retire_valid for warp 3 while INACTIVE -> err=1, warp states unchanged.
REQ-029 With WARP_SCHED_PERF_EN, 6 accepted issues and 3 empty RUN cycles -> perf_issue_count=6, perf_stall_cycles=3; reset=0 mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/warp_sched_if.sv
// Issue/retire handshake between warp_sched and the execution pipeline.
// master: scheduler side (offers warps, consumes retirements).
// slave:  pipeline side (accepts warps, reports retirements).
interface warp_sched_if #(
    parameter int unsigned NUM_WARPS        = 4,
    parameter int unsigned THREADS_PER_WARP = 4,
    parameter int unsigned PC_BITS          = 8
);
    localparam int unsigned ID_BITS = $clog2(NUM_WARPS);

    logic                        issue_valid;
    logic                        issue_ready;
    logic [ID_BITS-1:0]          issue_warp_id;
    logic [PC_BITS-1:0]          issue_pc;
    logic [THREADS_PER_WARP-1:0] issue_thread_mask;

    logic                        retire_valid;
    logic [ID_BITS-1:0]          retire_warp_id;
    logic [PC_BITS-1:0]          retire_next_pc;
    logic                        retire_done;

    modport master (
        output issue_valid, issue_warp_id, issue_pc, issue_thread_mask,
        input  issue_ready,
        input  retire_valid, retire_warp_id, retire_next_pc, retire_done
    );

    modport slave (
        input  issue_valid, issue_warp_id, issue_pc, issue_thread_mask,
        output issue_ready,
        output retire_valid, retire_warp_id, retire_next_pc, retire_done
    );
endinterface

// File: rtl/warp_sched.sv
// Warp scheduler: launches a thread block as up to NUM_WARPS warps, offers READY warps to the
// pipeline round-robin through a registered issue slot, and tracks one in-flight instruction
// per warp until every active warp has executed RET.
// Optional feature: define WARP_SCHED_PERF_EN to build the issue/stall performance counters;
// otherwise the perf ports are tied to zero.
module warp_sched #(
    parameter int unsigned NUM_WARPS        = 4,
    parameter int unsigned THREADS_PER_WARP = 4,
    parameter int unsigned PC_BITS          = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   thread_count,
    warp_sched_if.master pipe,
    output logic         done,
    output logic         err,
    output logic [15:0]  perf_issue_count,
    output logic [15:0]  perf_stall_cycles
);
    localparam int unsigned ID_BITS  = $clog2(NUM_WARPS);
    localparam int unsigned CAPACITY = NUM_WARPS * THREADS_PER_WARP;
    localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_WARPS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} top_state_e;
    typedef enum logic [2:0] {WInactive, WReady, WPending, WIssued, WFinished} warp_state_e;

    top_state_e                  state_q;
    warp_state_e                 warp_q [NUM_WARPS];
    logic [PC_BITS-1:0]          pc_q   [NUM_WARPS];
    logic [THREADS_PER_WARP-1:0] mask_q [NUM_WARPS];
    logic [ID_BITS-1:0]          rr_q;

    logic                        issue_valid_q;
    logic [ID_BITS-1:0]          issue_id_q;
    logic [PC_BITS-1:0]          issue_pc_q;
    logic [THREADS_PER_WARP-1:0] issue_mask_q;
    logic                        done_q;
    logic                        err_q;

    int unsigned                 tc;
    int unsigned                 rem;
    int unsigned                 launch_warps;
    logic                        launch_over;
    logic [THREADS_PER_WARP-1:0] tail_mask;

    int unsigned                 idx;
    logic [ID_BITS-1:0]          cand;
    logic                        sel_found;
    logic [ID_BITS-1:0]          sel_id;

    logic                        any_live;
    logic                        accept;
    logic                        retire_in_range;
    logic                        retire_hit;
    logic                        retire_bad;

    // Launch geometry: warp count (clamped) and the partial-lane mask of the last warp.
    always_comb begin
        tc           = 32'(thread_count);
        rem          = tc % THREADS_PER_WARP;
        launch_over  = tc > CAPACITY;
        launch_warps = launch_over ? NUM_WARPS : (tc + THREADS_PER_WARP - 1) / THREADS_PER_WARP;
        tail_mask    = '1;
        if (!launch_over && rem != 0) begin
            for (int unsigned j = 0; j < THREADS_PER_WARP; j++) begin
                tail_mask[j] = j < rem;
            end
        end
    end

    // Round-robin pick of the first READY warp after the last one loaded into the slot.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
            idx  = (32'(rr_q) + i) % NUM_WARPS;
            cand = ID_BITS'(idx);
            if (!sel_found && warp_q[cand] == WReady) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // Handshake decode and the "some warp still has work" flag.
    always_comb begin
        any_live = 1'b0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            if (warp_q[w] inside {WReady, WPending, WIssued}) begin
                any_live = 1'b1;
            end
        end
        accept          = issue_valid_q && pipe.issue_ready;
        retire_in_range = 32'(pipe.retire_warp_id) < NUM_WARPS;
        retire_hit      = pipe.retire_valid && retire_in_range &&
                          (warp_q[pipe.retire_warp_id] == WIssued);
        retire_bad      = pipe.retire_valid && !retire_hit;
    end

    // Top FSM, per-warp state, issue slot and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                warp_q[w] <= WInactive;
                pc_q[w]   <= '0;
                mask_q[w] <= '0;
            end
            rr_q          <= LAST_ID;
            issue_valid_q <= 1'b0;
            issue_id_q    <= '0;
            issue_pc_q    <= '0;
            issue_mask_q  <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            if (retire_bad) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (launch_over) begin
                            err_q <= 1'b1;
                        end
                        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                            warp_q[w] <= (w < launch_warps) ? WReady : WInactive;
                            pc_q[w]   <= '0;
                            mask_q[w] <= (w + 1 == launch_warps) ? tail_mask : '1;
                        end
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (accept) begin
                        warp_q[issue_id_q] <= WIssued;
                    end
                    // Retire and accept always target different warps, so both apply.
                    if (retire_hit) begin
                        if (pipe.retire_done) begin
                            warp_q[pipe.retire_warp_id] <= WFinished;
                        end else begin
                            warp_q[pipe.retire_warp_id] <= WReady;
                            pc_q[pipe.retire_warp_id]   <= pipe.retire_next_pc;
                        end
                    end
                    // Selection sees pre-edge state, so a warp retired now waits one edge.
                    if (!issue_valid_q || accept) begin
                        issue_valid_q <= sel_found;
                        if (sel_found) begin
                            warp_q[sel_id] <= WPending;
                            issue_id_q     <= sel_id;
                            issue_pc_q     <= pc_q[sel_id];
                            issue_mask_q   <= mask_q[sel_id];
                            rr_q           <= sel_id;
                        end
                    end
                    if (!any_live) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign pipe.issue_valid       = issue_valid_q;
    assign pipe.issue_warp_id     = issue_id_q;
    assign pipe.issue_pc          = issue_pc_q;
    assign pipe.issue_thread_mask = issue_mask_q;
    assign done                   = done_q;
    assign err                    = err_q;

`ifdef WARP_SCHED_PERF_EN
    logic [15:0] perf_issue_q;
    logic [15:0] perf_stall_q;

    // Saturating accepted-issue and empty-slot counters, cleared at launch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else if (state_q == StIdle && start) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else if (state_q == StRun) begin
            if (accept && perf_issue_q != 16'hFFFF) begin
                perf_issue_q <= perf_issue_q + 16'd1;
            end
            if (!issue_valid_q && perf_stall_q != 16'hFFFF) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_issue_count  = perf_issue_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_issue_count  = 16'd0;
    assign perf_stall_cycles = 16'd0;
`endif

endmodule
